// File: rtl/gf_pkg.sv
// Shared definitions for the hit-combination front end.
// Contents:
//   - layer-count constants (NSVX, NLAYER, HIT_W, Z_W)
//   - the combination sequencer FSM state encoding
//   - comb_t: the combination record handed to the track-fit stage
//   - popcount_svx(): number of empty SVX layers in a combination
package gf_pkg;

  localparam int NSVX   = 5;
  localparam int NLAYER = 6;
  localparam int HIT_W  = 16;
  localparam int Z_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_WAIT,
    S_FINISH,
    S_CLEAR
  } seq_state_t;

  typedef struct packed {
    logic [NSVX-1:0][HIT_W-1:0] hit;   // hit[i] = SVX layer i
    logic signed [HIT_W-1:0]    c;     // XFT curvature
    logic signed [HIT_W-1:0]    phi;   // XFT phi
    logic [2*Z_W-1:0]           z;     // {zout, zin}
    logic [NLAYER-1:0]          mask;  // empty flags, bit 5 = XFT
    logic                       last;
  } comb_t;

  function automatic logic [2:0] popcount_svx(input logic [NSVX-1:0] e);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NSVX; i++) n = n + {2'b00, e[i]};
    return n;
  endfunction

endpackage

// File: rtl/comb_sequencer_if.sv
// Combination output bus toward the track-fit stage.
// master (sequencer) drives comb_valid and the record fields; slave
// (fit stage) drives comb_ready. A word moves when valid & ready.
interface comb_sequencer_if;
  import gf_pkg::*;

  logic                    comb_valid;
  logic                    comb_ready;
  logic [HIT_W-1:0]        comb_hit_0;
  logic [HIT_W-1:0]        comb_hit_1;
  logic [HIT_W-1:0]        comb_hit_2;
  logic [HIT_W-1:0]        comb_hit_3;
  logic [HIT_W-1:0]        comb_hit_4;
  logic signed [HIT_W-1:0] comb_c;
  logic signed [HIT_W-1:0] comb_phi;
  logic [2*Z_W-1:0]        comb_z;
  logic [NLAYER-1:0]       comb_mask;
  logic                    comb_last;

  modport master (
    output comb_valid, comb_hit_0, comb_hit_1, comb_hit_2, comb_hit_3,
           comb_hit_4, comb_c, comb_phi, comb_z, comb_mask, comb_last,
    input  comb_ready
  );

  modport slave (
    input  comb_valid, comb_hit_0, comb_hit_1, comb_hit_2, comb_hit_3,
           comb_hit_4, comb_c, comb_phi, comb_z, comb_mask, comb_last,
    output comb_ready
  );

endinterface

// File: rtl/comb_outreg.sv
// Single-entry output register with valid/ready handshake.
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   load          - write din this cycle (only honoured when can_load)
//   din           - combination record to capture
//   ready         - downstream accepts the held word
//   valid, dout   - held word and its valid flag
//   can_load      - register empty or being drained this cycle, so a
//                   load now causes neither loss nor a bubble
module comb_outreg
  import gf_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  comb_t din,
  input  logic  ready,
  output logic  valid,
  output comb_t dout,
  output logic  can_load
);

  logic  vld_p0;
  comb_t comb_p0;

  assign can_load = !vld_p0 || ready;
  assign valid    = vld_p0;
  assign dout     = comb_p0;

  // stage p0: output register
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      comb_p0 <= '0;
    end else if (load && can_load) begin
      vld_p0  <= 1'b1;
      comb_p0 <= din;
    end else if (vld_p0 && ready) begin
      vld_p0  <= 1'b0;
    end
  end

endmodule

// File: rtl/comb_sequencer.sv
// Hit-combination sequencer: steps the hit bank through every SVX/XFT
// combination of one event, drops combinations with too many empty
// SVX layers, presents the rest on a valid/ready bus and finally clears
// and resets the hit bank.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   ev_start              - hit bank loaded, begin walking the event
//   empty, glast          - per-layer empty flags / final-combination flag
//   hit_0..hit_4          - SVX hit words of the presented combination
//   xft_c, xft_phi        - XFT track parameters (signed)
//   zin, zout             - z-sector bits
//   gnext                 - advance the hit bank to the next combination
//   hb_clear, hb_reset    - end-of-event clear/reset pulses to hit bank
//   ev_done               - end-of-event pulse
//   n_emitted, n_rejected - per-event counts, saturating
//   overrun               - sticky: ev_start seen while busy
//   truncated             - (COMB_LIMIT_EN only) event hit MAX_COMBS
//   comb                  - combination output bus (master)
// Build option: define COMB_LIMIT_EN to cap each event at MAX_COMBS
// combinations and add the truncated output.
module comb_sequencer
  import gf_pkg::*;
#(
  parameter int MAX_MISSING = 1,
  parameter int MAX_COMBS   = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ev_start,
  input  logic [NLAYER-1:0]       empty,
  input  logic                    glast,
  input  logic [HIT_W-1:0]        hit_0,
  input  logic [HIT_W-1:0]        hit_1,
  input  logic [HIT_W-1:0]        hit_2,
  input  logic [HIT_W-1:0]        hit_3,
  input  logic [HIT_W-1:0]        hit_4,
  input  logic signed [HIT_W-1:0] xft_c,
  input  logic signed [HIT_W-1:0] xft_phi,
  input  logic [Z_W-1:0]          zin,
  input  logic [Z_W-1:0]          zout,
  output logic                    gnext,
  output logic                    hb_clear,
  output logic                    hb_reset,
  output logic                    ev_done,
  output logic [CNT_W-1:0]        n_emitted,
  output logic [CNT_W-1:0]        n_rejected,
  output logic                    overrun,
`ifdef COMB_LIMIT_EN
  output logic                    truncated,
`endif
  comb_sequencer_if.master        comb
);

`ifdef COMB_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif
  localparam int TW = CNT_W + 1;

  seq_state_t     state, state_n;
  logic           first_q;
  logic           can_load, load, take, accept, lim_hit, end_c, out_vld;
  logic [2:0]     missing;
  logic [TW-1:0]  tot_next;
  comb_t          cand, out_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign missing  = popcount_svx(empty[NSVX-1:0]);
  assign accept   = (int'(missing) <= MAX_MISSING) && !empty[NSVX];
  // Count including the combination being examined now.
  assign tot_next = {1'b0, n_emitted} + {1'b0, n_rejected} + TW'(1);
  assign lim_hit  = LIMIT_ON && (tot_next >= TW'(MAX_COMBS));
  assign end_c    = glast || lim_hit;

  always_comb begin
    cand      = '0;
    cand.hit  = {hit_4, hit_3, hit_2, hit_1, hit_0};
    cand.c    = xft_c;
    cand.phi  = xft_phi;
    cand.z    = {zout, zin};
    cand.mask = empty;
    cand.last = end_c;
  end

  always_comb begin
    state_n  = state;
    gnext    = 1'b0;
    hb_clear = 1'b0;
    hb_reset = 1'b0;
    ev_done  = 1'b0;
    take     = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE:   if (ev_start) state_n = S_SETTLE;
      // An event with no XFT track has nothing to combine.
      S_SETTLE: state_n = (first_q && empty[NSVX]) ? S_FINISH : S_CAPTURE;
      S_CAPTURE, S_WAIT: begin
        if (!can_load) begin
          state_n = S_WAIT;
        end else begin
          take = 1'b1;
          load = accept;
          if (end_c) begin
            state_n = S_FINISH;
          end else begin
            gnext   = 1'b1;
            state_n = S_SETTLE;
          end
        end
      end
      S_FINISH: if (!out_vld) state_n = S_CLEAR;
      S_CLEAR: begin
        hb_clear = 1'b1;
        hb_reset = 1'b1;
        ev_done  = 1'b1;
        state_n  = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      first_q    <= 1'b0;
      n_emitted  <= '0;
      n_rejected <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_n;
      if (ev_start && state != S_IDLE) overrun <= 1'b1;
      if (ev_start && state == S_IDLE) begin
        first_q    <= 1'b1;
        n_emitted  <= '0;
        n_rejected <= '0;
      end else begin
        if (state == S_SETTLE) first_q <= 1'b0;
        if (take) begin
          if (accept) n_emitted  <= sat_inc(n_emitted);
          else        n_rejected <= sat_inc(n_rejected);
        end
      end
    end
  end

`ifdef COMB_LIMIT_EN
  always_ff @(posedge clock) begin
    if (reset)                          truncated <= 1'b0;
    else if (ev_start && state == S_IDLE) truncated <= 1'b0;
    else if (take && lim_hit)           truncated <= 1'b1;
  end
`endif

  comb_outreg u_outreg (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .din      (cand),
    .ready    (comb.comb_ready),
    .valid    (out_vld),
    .dout     (out_q),
    .can_load (can_load)
  );

  assign comb.comb_valid = out_vld;
  assign comb.comb_hit_0 = out_q.hit[0];
  assign comb.comb_hit_1 = out_q.hit[1];
  assign comb.comb_hit_2 = out_q.hit[2];
  assign comb.comb_hit_3 = out_q.hit[3];
  assign comb.comb_hit_4 = out_q.hit[4];
  assign comb.comb_c     = out_q.c;
  assign comb.comb_phi   = out_q.phi;
  assign comb.comb_z     = out_q.z;
  assign comb.comb_mask  = out_q.mask;
  assign comb.comb_last  = out_q.last;

endmodule

// File: tb/tb_comb_sequencer.sv
// Directed bench for comb_sequencer with a behavioural hit bank whose
// pointer advances on gnext and returns to 0 on hb_reset or reset.
// Hit word of layer k at pointer p is k*256+p (0 for empty layers).
module tb_comb_sequencer;
  import gf_pkg::*;

`ifdef COMB_LIMIT_EN
  localparam int LIM = 4;
`else
  localparam int LIM = 1024;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ev_start = 1'b0;
  logic [NLAYER-1:0] empty;
  logic glast;
  logic [HIT_W-1:0] hit_0, hit_1, hit_2, hit_3, hit_4;
  logic signed [HIT_W-1:0] xft_c, xft_phi;
  logic [Z_W-1:0] zin, zout;
  logic gnext, hb_clear, hb_reset, ev_done, overrun;
  logic [10:0] n_emitted, n_rejected;
`ifdef COMB_LIMIT_EN
  logic truncated;
`endif

  comb_sequencer_if cif ();

  comb_sequencer #(.MAX_MISSING(1), .MAX_COMBS(LIM), .CNT_W(11)) dut (
    .clock(clock), .reset(reset), .ev_start(ev_start), .empty(empty),
    .glast(glast), .hit_0(hit_0), .hit_1(hit_1), .hit_2(hit_2),
    .hit_3(hit_3), .hit_4(hit_4), .xft_c(xft_c), .xft_phi(xft_phi),
    .zin(zin), .zout(zout), .gnext(gnext), .hb_clear(hb_clear),
    .hb_reset(hb_reset), .ev_done(ev_done), .n_emitted(n_emitted),
    .n_rejected(n_rejected), .overrun(overrun),
`ifdef COMB_LIMIT_EN
    .truncated(truncated),
`endif
    .comb(cif)
  );

  always #5 clock = ~clock;

  // hit bank model
  int unsigned ptr;
  int unsigned n_pres = 1;
  logic [NLAYER-1:0] empty_cfg = '0;

  always @(posedge clock) begin
    if (reset || hb_reset) ptr <= 0;
    else if (gnext)        ptr <= ptr + 1;
  end

  function automatic logic [HIT_W-1:0] hw(input int k, input int unsigned p);
    return empty_cfg[k] ? '0 : HIT_W'(k * 256 + int'(p));
  endfunction

  always_comb begin
    empty   = empty_cfg;
    glast   = (ptr + 1 >= n_pres);
    hit_0   = hw(0, ptr);
    hit_1   = hw(1, ptr);
    hit_2   = hw(2, ptr);
    hit_3   = hw(3, ptr);
    hit_4   = hw(4, ptr);
    xft_c   = ~ptr[15:0];
    xft_phi = HIT_W'(ptr * 3);
    zin     = ptr[5:0];
    zout    = ~ptr[5:0];
  end

  // monitor, sampled on the falling edge
  int cyc = 0, n_words = 0, n_gn = 0, n_ed = 0, n_clr = 0, n_hbr = 0, n_vld = 0;
  logic [HIT_W-1:0] w_h0[$], w_h1[$], w_h4[$], w_c[$];
  logic [11:0] w_z[$];
  logic w_last[$];
  int w_cyc[$];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (cif.comb_valid) n_vld <= n_vld + 1;
    if (cif.comb_valid && cif.comb_ready) begin
      n_words <= n_words + 1;
      w_h0.push_back(cif.comb_hit_0);
      w_h1.push_back(cif.comb_hit_1);
      w_h4.push_back(cif.comb_hit_4);
      w_c.push_back(cif.comb_c);
      w_z.push_back(cif.comb_z);
      w_last.push_back(cif.comb_last);
      w_cyc.push_back(cyc);
    end
    if (gnext)    n_gn  <= n_gn + 1;
    if (ev_done)  n_ed  <= n_ed + 1;
    if (hb_clear) n_clr <= n_clr + 1;
    if (hb_reset) n_hbr <= n_hbr + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (n_ed == base && k < budget) begin
      tick(1);
      k++;
    end
    chk("ev_done_seen", 64'(n_ed != base), 64'd1);
    tick(2);
  endtask

  int w0, g0, e0, c0, h0, v0, qb, ne;

  initial begin
    cif.comb_ready = 1'b1;
    tick(3);
    chk("rst_valid", cif.comb_valid, 0);
    chk("rst_gnext", gnext, 0);
    chk("rst_evdone", ev_done, 0);
    chk("rst_clear", hb_clear, 0);
    chk("rst_nemit", n_emitted, 0);
    chk("rst_nrej", n_rejected, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mask", cif.comb_mask, 0);
    reset = 1'b0;
    tick(2);

    // 1: full event, 32 combinations, always ready
    n_pres = 32; empty_cfg = '0;
    ne = (32 < LIM) ? 32 : LIM;
    w0 = n_words; g0 = n_gn; e0 = n_ed; c0 = n_clr; h0 = n_hbr; qb = w_h0.size();
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    tick(1);
    chk("lat_valid_early", cif.comb_valid, 0);
    tick(1);
    chk("lat_valid_3", cif.comb_valid, 1);
    wait_done(e0, 400);
    chk("t1_words", n_words - w0, ne);
    chk("t1_gnext", n_gn - g0, ne - 1);
    chk("t1_evdone", n_ed - e0, 1);
    chk("t1_clear", n_clr - c0, 1);
    chk("t1_hbreset", n_hbr - h0, 1);
    chk("t1_nemit", n_emitted, ne);
    chk("t1_nrej", n_rejected, 0);
    chk("t1_last", w_last[qb + ne - 1], 1);
    chk("t1_notlast", w_last[qb + ne - 2], 0);
    chk("t1_h0_last", w_h0[qb + ne - 1], ne - 1);
    chk("t1_h1_first", w_h1[qb], 256);
    chk("t1_h4_last", w_h4[qb + ne - 1], 4 * 256 + ne - 1);
    chk("t1_c_1", w_c[qb + 1], 16'hFFFE);
    chk("t1_z_2", w_z[qb + 2], 12'hF42);
    chk("t1_rate", w_cyc[qb + ne - 1] - w_cyc[qb], 2 * (ne - 1));
`ifdef COMB_LIMIT_EN
    chk("t1_truncated", truncated, 1);
`endif

    // 2: layers 2 and 4 empty -> everything rejected
    n_pres = 8; empty_cfg = 6'b010100;
    ne = (8 < LIM) ? 8 : LIM;
    w0 = n_words; g0 = n_gn; e0 = n_ed; v0 = n_vld;
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    wait_done(e0, 200);
    chk("t2_words", n_words - w0, 0);
    chk("t2_vld", n_vld - v0, 0);
    chk("t2_nrej", n_rejected, ne);
    chk("t2_nemit", n_emitted, 0);
    chk("t2_gnext", n_gn - g0, ne - 1);

    // 3: no XFT track -> immediate finish
    n_pres = 8; empty_cfg = 6'b100000;
    g0 = n_gn; e0 = n_ed; v0 = n_vld;
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    tick(2);
    chk("t3_evdone_3", ev_done, 1);
    chk("t3_clear", hb_clear, 1);
    chk("t3_hbreset", hb_reset, 1);
    tick(1);
    chk("t3_evdone_off", ev_done, 0);
    tick(2);
    chk("t3_gnext", n_gn - g0, 0);
    chk("t3_vld", n_vld - v0, 0);
    chk("t3_nemit", n_emitted, 0);
    chk("t3_nrej", n_rejected, 0);

    // 4: stall the output for 10 cycles after the first word
    n_pres = 4; empty_cfg = '0; cif.comb_ready = 1'b0;
    w0 = n_words; g0 = n_gn; e0 = n_ed; qb = w_h0.size();
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t4_stall_data", cif.comb_hit_1, 256);
      chk("t4_stall_gnext", gnext, 0);
    end
    chk("t4_gnext_count", n_gn - g0, 1);
    cif.comb_ready = 1'b1;
    wait_done(e0, 200);
    chk("t4_words", n_words - w0, 4);
    for (int i = 0; i < 4; i++) chk("t4_seq", w_h1[qb + i], 256 + i);
    chk("t4_last", w_last[qb + 3], 1);
    chk("t4_nemit", n_emitted, 4);

    // 5: ev_start while busy, then reset mid-event
    n_pres = 4; empty_cfg = '0;
    chk("t5_overrun_pre", overrun, 0);
    w0 = n_words; e0 = n_ed;
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    tick(2);
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    chk("t5_overrun", overrun, 1);
    wait_done(e0, 200);
    chk("t5_overrun_sticky", overrun, 1);
    chk("t5_words", n_words - w0, 4);
    chk("t5_nemit", n_emitted, 4);

    n_pres = 8;
    ev_start = 1'b1; tick(1); ev_start = 1'b0;
    tick(4);
    c0 = n_clr; e0 = n_ed;
    reset = 1'b1; tick(1);
    chk("t5_rst_valid", cif.comb_valid, 0);
    chk("t5_rst_gnext", gnext, 0);
    chk("t5_rst_hit1", cif.comb_hit_1, 0);
    chk("t5_rst_nemit", n_emitted, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_clear", hb_clear, 0);
    reset = 1'b0;
    tick(5);
    chk("t5_no_clear", n_clr - c0, 0);
    chk("t5_no_evdone", n_ed - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comb_sequencer.md
Name: comb_sequencer

Overview:
- Sits directly downstream of the per-layer hit register bank.
- Walks through every hit combination (5 SVX layers + 1 XFT track) for one event by pulsing `gnext` and watching `glast`.
- Captures each combination into an output register with a valid/ready handshake toward the track-fit stage.
- Rejects combinations with too many empty layers, then clears and resets the hit bank at end of event.

Parameters:
- MAX_MISSING, 1, maximum number of empty SVX layers (`empty[4:0]`) allowed in an emitted combination.
- MAX_COMBS, 1024, combination cap per event; used only with COMB_LIMIT_EN.
- CNT_W, 11, width of the per-event combination counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ev_start  in  1  one-cycle pulse: hit bank fully loaded for the event
- empty  in  6  per-layer empty flags from the hit bank, registered there; bit 5 = XFT
- glast  in  1  sticky "final combination presented" flag from the hit bank
- hit_0..hit_4  in  16 each  SVX hit words for the current combination
- xft_c, xft_phi  in  16 each  XFT curvature and phi, two's complement
- zin, zout  in  6 each  z-sector bits
- gnext  out  1  advance pulse to the hit bank
- hb_clear  out  1  clear pulse to the hit bank
- hb_reset  out  1  reset pulse to the hit bank
- comb_valid  out  1  output register holds a combination
- comb_ready  in  1  fit stage accepts
- comb_hit_0..comb_hit_4, comb_c, comb_phi  out  16 each  captured words
- comb_z  out  12  {zout, zin}
- comb_mask  out  6  captured empty flags
- comb_last  out  1  this combination is the event's final one
- ev_done  out  1  one-cycle pulse at end of event
- n_emitted, n_rejected  out  CNT_W  per-event counts, held until the next ev_start
- overrun  out  1  sticky: ev_start arrived while not IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including registers and counters.
- FSM states: IDLE, SETTLE, CAPTURE, WAIT, FINISH, CLEAR.
- IDLE:
  - On ev_start: zero both counters, go to SETTLE.
  - If ev_start arrives in any other state: set `overrun`; the pulse is otherwise ignored.
- SETTLE (1 cycle): lets the registered `empty` and `glast` reflect the current pointer.
  - Next state CAPTURE, except on the first SETTLE of an event with `empty[5]`=1: go to FINISH with zero combinations.
- CAPTURE (fires only when `comb_valid`=0, or `comb_ready`=1 in the same cycle):
  - Count missing = popcount(`empty[4:0]`).
  - Accept when missing <= MAX_MISSING and `empty[5]`=0:
    - Load all data into the output register. Data words of empty layers are already 0 from upstream; pass them unchanged.
    - `comb_mask` <= `empty`; `comb_last` <= `glast`; `comb_valid` <= 1; n_emitted++.
  - Otherwise: n_rejected++ and leave the output register untouched.
  - If `glast`=0: pulse `gnext` for 1 cycle, go to SETTLE.
  - If `glast`=1: go to FINISH; no `gnext`.
- WAIT: entered from CAPTURE when the output register is full and not being drained. Stays there until the drain condition holds, then behaves as CAPTURE. `gnext` is never asserted while the register is stalled.
- Throughput: at most 1 combination per 2 cycles. Latency from ev_start to first `comb_valid` = 3 cycles.
- Handshake:
  - Transfer occurs when `comb_valid` & `comb_ready`.
  - Once asserted, `comb_valid` and the data stay stable until transfer.
  - Simultaneous transfer and capture reloads the register with no bubble.
- A final rejected combination produces no `comb_last` word. The fit stage uses `ev_done` as the authoritative event end.
- FINISH: wait until `comb_valid`=0 (the last word is drained), then go to CLEAR.
- CLEAR (1 cycle): pulse `hb_clear` and `hb_reset` together and pulse `ev_done`; go to IDLE.
- Counters saturate at all-ones.
- `reset` asserted mid-event: immediately IDLE, outputs 0. No `hb_clear` is issued; the global reset also resets the hit bank.

Optional Feature:
- Macro: COMB_LIMIT_EN.
- Defined:
  - When n_emitted + n_rejected reaches MAX_COMBS in CAPTURE, treat it as `glast`=1 and force `comb_last` on any accepted word.
  - Add output `truncated` (1 bit): set in that cycle, cleared on the next ev_start, 0 at reset.
- Not defined: no limit and no `truncated` port; the event is bounded only by `glast`.

Decomposition:
- Shared package `gf_pkg`:
  - layer count constants: NSVX=5, NLAYER=6, HIT_W=16, Z_W=6
  - FSM state encoding
  - the combination record layout, also used by the fit stage
- One natural sub-module, `comb_outreg`: the output register with valid/ready, load enable and stall logic.

Test Plan:
- 2 hits in each of 5 layers, 1 track, glast after 32nd presentation, comb_ready=1 -> 32 valid words, one every 2 cycles; the 32nd has comb_last=1; ev_done pulses once; n_emitted=32, n_rejected=0; hb_clear and hb_reset pulse once.
- Layer 2 and layer 4 empty, MAX_MISSING=1 -> every combination rejected, comb_valid never rises, n_rejected equals the combination count, ev_done still pulses.
- empty[5]=1 at ev_start -> no gnext, no comb_valid, ev_done 3 cycles after ev_start, counters 0.
- comb_ready held 0 for 10 cycles after the first word -> data stable, gnext held 0 during the stall, no loss or duplication after release.
- ev_start pulsed mid-event -> overrun=1 and sticky; event completes normally; reset mid-event -> all outputs 0 on the next cycle.
- COMB_LIMIT_EN with MAX_COMBS=4 and glast after 32 presentations -> exactly 4 captures, 4th word has comb_last=1, truncated=1, 3 gnext pulses.
